rr_mux_arbiter: RTL and testbench
=================================

# rr_mux_arbiter

Round-robin arbiter and sequencer for the shared 4:1 one-bit multiplexer path. Four requesters compete for the path; the block grants one at a time and drives the `select1`/`select2` mux selects. It also produces a registered copy of the selected data bit as `q`. Grants are held until release or timeout, so no requester can starve the others.

## Interface
Parameters:
- `MAX_HOLD`, default 8, maximum cycles a single grant may last; legal range 2..255; counter width `$clog2(MAX_HOLD)`.

Ports:
- `clk`  in  1  single clock, all state updates on rising edge.
- `rst_n`  in  1  asynchronous active-low reset; one clock, reset is asynchronous and active-low.
- `req`  in  4  request per requester; bit 0 = A, 1 = B, 2 = C, 3 = D.
- `done`  in  1  current owner releases the path; ignored when no grant is active.
- `A`, `B`, `C`, `D`  in  1 each  data inputs of the shared path.
- `grant`  out  4  one-hot grant, registered; all-zero when idle.
- `select1`  out  1  mux select MSB, registered.
- `select2`  out  1  mux select LSB, registered.
- `busy`  out  1  high while a grant is active; equals `|grant`.
- `q`  out  1  registered output of the selected data bit.

## Operation
- States:
  - IDLE: no grant.
  - GRANT: one requester owns the path.
- Pointer `ptr` (2 bits) gives the highest-priority index. Search order is `ptr`, `ptr+1`, `ptr+2`, `ptr+3`, mod 4.
- IDLE -> GRANT: at an edge where `req != 0`, the first set bit in search order becomes owner `idx`. At that edge:
  - `grant <= 1<<idx`
  - `{select1,select2} <= idx`, with encoding 00 = A, 01 = B, 10 = C, 11 = D
  - `ptr <= idx+1` (wraps 3 -> 0)
  - `cnt <= 0`
- In GRANT, release occurs at an edge where any of the following holds:
  - `done` = 1,
  - `req[idx]` = 0,
  - `cnt == MAX_HOLD-1`.

  Multiple release causes in the same cycle produce a single release. Otherwise `cnt` increments.
- On release: `grant <= 0` and state returns to IDLE. IDLE lasts at least one cycle, which is a mandatory dead cycle between owners. `select1`/`select2` hold their last value.
- `q`: in GRANT, `q <= ` the data input chosen by the current selects, each cycle. In IDLE, `q <= 0`.
- `req` changes in IDLE with no grant pending have no effect beyond the next arbitration.

## Timing
- Reset values (asynchronous, immediate on `rst_n` low):
  - state IDLE
  - `grant` = 0000
  - `select1` = `select2` = 0
  - `busy` = 0
  - `q` = 0
  - `ptr` = 0
  - `cnt` = 0
- Grant latency: `req` high before edge N, with the block in IDLE -> `grant`, `busy` and selects valid after edge N.
- Data latency: `q` reflects the owner's data bit one cycle after the grant appears, then tracks it with one cycle of delay.
- Timeout: without `done`, `grant` is high for exactly `MAX_HOLD` cycles.
- `done` sampled in the first GRANT cycle gives a one-cycle grant.
- Minimum owner-to-owner gap is 1 idle cycle. Back-to-back arbitration inside GRANT is not permitted.
- Reset mid-grant: all outputs return to reset values immediately. After deassertion, arbitration restarts from `ptr` = 0.

## Test plan
- Reset: hold `rst_n` = 0 with `req` = 1111 -> `grant` = 0000, `q` = 0, selects 00. Release reset -> after the next edge, `grant` = 0001, selects 00.
- Single requester: `req` = 0100, `C` = 1. Expected:
  - `grant` = 0100 and `{select1,select2}` = 10 after one edge.
  - `q` = 1 one cycle later.
  - Assert `done` -> `grant` = 0000 and `q` = 0 on the next edges.
- Round robin: `req` = 1111 held, `done` pulsed in each grant's first cycle -> grant sequence 0001, 0010, 0100, 1000, 0001, with one idle cycle between each pair.
- Timeout: `MAX_HOLD` = 8, `req` = 0011 held, `done` = 0. Expected:
  - `grant` = 0001 for exactly 8 cycles.
  - 1 idle cycle.
  - `grant` = 0010 for 8 cycles.
- Request drop: granted `req[3]` falls in its third grant cycle -> `grant` = 0000 at the next edge. `ptr` advances, so with `req` = 1001 the next grant is 0001.
- Async reset mid-grant: pull `rst_n` low between edges during `grant` = 0010 -> outputs clear without waiting for a clock edge. After release, `req` = 0110 grants 0010 (`ptr` = 0).

Source files
------------

// File: rtl/rr_mux_arbiter.sv
// rtl/rr_mux_arbiter.sv - round-robin arbiter driving the shared 4:1 one-bit mux path
module rr_mux_arbiter #(
    parameter int MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic       done,
    input  logic       A,
    input  logic       B,
    input  logic       C,
    input  logic       D,
    output logic [3:0] grant,
    output logic       select1,
    output logic       select2,
    output logic       busy,
    output logic       q
);

    localparam int CW = $clog2(MAX_HOLD);
    localparam logic [CW-1:0] LAST = CW'(MAX_HOLD - 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t        state;
    logic [1:0]    ptr;
    logic [CW-1:0] cnt;

    logic [1:0] owner;
    logic [3:0] data;
    logic       found;
    logic [1:0] pick;
    logic [1:0] cand;
    logic       release_now;

    // The selects double as the owner index while a grant is active.
    assign owner = {select1, select2};
    assign data  = {D, C, B, A};
    assign busy  = |grant;

    always_comb begin
        found = 1'b0;
        pick  = ptr;
        cand  = ptr;
        for (int i = 0; i < 4; i++) begin
            cand = ptr + 2'(i);
            if (!found && req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    assign release_now = done || !req[owner] || (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            grant   <= 4'b0000;
            select1 <= 1'b0;
            select2 <= 1'b0;
            q       <= 1'b0;
            ptr     <= 2'd0;
            cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    q <= 1'b0;
                    if (found) begin
                        state              <= GRANT;
                        grant              <= 4'b0001 << pick;
                        {select1, select2} <= pick;
                        ptr                <= pick + 2'd1;
                        cnt                <= '0;
                    end
                end
                GRANT: begin
                    q <= data[owner];
                    // Selects hold their value through the dead cycle that follows.
                    if (release_now) begin
                        state <= IDLE;
                        grant <= 4'b0000;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// tb/tb_rr_mux_arbiter.sv - directed vector bench for rr_mux_arbiter
module tb_rr_mux_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = 4'b0000;
    logic       done = 1'b0;
    logic [3:0] data = 4'b0000;
    logic [3:0] grant;
    logic       select1;
    logic       select2;
    logic       busy;
    logic       q;

    int n_checks = 0;
    int n_fail   = 0;

    rr_mux_arbiter #(.MAX_HOLD(8)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .done    (done),
        .A       (data[0]),
        .B       (data[1]),
        .C       (data[2]),
        .D       (data[3]),
        .grant   (grant),
        .select1 (select1),
        .select2 (select2),
        .busy    (busy),
        .q       (q)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] req;
        logic       done;
        logic [3:0] data;
        logic [3:0] g;
        logic [1:0] sel;
        logic       q;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic [3:0] r, input logic d, input logic [3:0] dat,
                       input logic [3:0] g, input logic [1:0] s, input logic qq);
        vec_t v;
        v.req = r; v.done = d; v.data = dat; v.g = g; v.sel = s; v.q = qq;
        vq.push_back(v);
    endtask

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = 4'b0000;
        done  = 1'b0;
        data  = 4'b0000;
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        // round robin from ptr=0, done pulsed in each first grant cycle
        add(4'b1111, 0, 4'b0000, 4'b0001, 2'b00, 0);
        add(4'b1111, 1, 4'b0000, 4'b0000, 2'b00, 0);
        add(4'b1111, 0, 4'b0000, 4'b0010, 2'b01, 0);
        add(4'b1111, 1, 4'b0000, 4'b0000, 2'b01, 0);
        add(4'b1111, 0, 4'b0000, 4'b0100, 2'b10, 0);
        add(4'b1111, 1, 4'b0000, 4'b0000, 2'b10, 0);
        add(4'b1111, 0, 4'b0000, 4'b1000, 2'b11, 0);
        add(4'b1111, 1, 4'b0000, 4'b0000, 2'b11, 0);
        add(4'b1111, 0, 4'b0000, 4'b0001, 2'b00, 0);
        add(4'b1111, 1, 4'b0000, 4'b0000, 2'b00, 0);
        // single requester C, q tracks C with one cycle of delay
        add(4'b0100, 0, 4'b0100, 4'b0100, 2'b10, 0);
        add(4'b0100, 0, 4'b0100, 4'b0100, 2'b10, 1);
        add(4'b0100, 0, 4'b0000, 4'b0100, 2'b10, 0);
        add(4'b0100, 0, 4'b0100, 4'b0100, 2'b10, 1);
        add(4'b0100, 1, 4'b0100, 4'b0000, 2'b10, 1);
        add(4'b0000, 0, 4'b0100, 4'b0000, 2'b10, 0);
        // request drop by D in its third grant cycle, then A wins at ptr=0
        add(4'b1000, 0, 4'b1000, 4'b1000, 2'b11, 0);
        add(4'b1000, 0, 4'b1000, 4'b1000, 2'b11, 1);
        add(4'b1000, 0, 4'b1000, 4'b1000, 2'b11, 1);
        add(4'b0001, 0, 4'b1000, 4'b0000, 2'b11, 1);
        add(4'b1001, 0, 4'b1000, 4'b0001, 2'b00, 0);
        add(4'b1001, 1, 4'b1000, 4'b0000, 2'b00, 0);
        add(4'b0000, 0, 4'b1000, 4'b0000, 2'b00, 0);

        // reset held with all requests present
        rst_n = 1'b0;
        req   = 4'b1111;
        repeat (2) step();
        check("reset_grant", {4'b0, grant}, 8'h00);
        check("reset_sel", {6'b0, select1, select2}, 8'h00);
        check("reset_q", {7'b0, q}, 8'h00);
        check("reset_busy", {7'b0, busy}, 8'h00);
        rst_n = 1'b1;
        step();
        check("post_reset_grant", {4'b0, grant}, 8'h01);
        check("post_reset_sel", {6'b0, select1, select2}, 8'h00);

        do_reset();
        foreach (vq[i]) begin
            req  = vq[i].req;
            done = vq[i].done;
            data = vq[i].data;
            step();
            check($sformatf("vec%0d_grant", i), {4'b0, grant}, {4'b0, vq[i].g});
            check($sformatf("vec%0d_sel", i), {6'b0, select1, select2}, {6'b0, vq[i].sel});
            check($sformatf("vec%0d_q", i), {7'b0, q}, {7'b0, vq[i].q});
            check($sformatf("vec%0d_busy", i), {7'b0, busy}, {7'b0, |vq[i].g});
        end

        // timeout: each owner holds for exactly MAX_HOLD cycles
        do_reset();
        req = 4'b0011;
        for (int k = 0; k < 8; k++) begin
            step();
            check($sformatf("timeout_a%0d", k), {4'b0, grant}, 8'h01);
        end
        step();
        check("timeout_gap", {4'b0, grant}, 8'h00);
        for (int k = 0; k < 8; k++) begin
            step();
            check($sformatf("timeout_b%0d", k), {4'b0, grant}, 8'h02);
        end
        step();
        check("timeout_end", {4'b0, grant}, 8'h00);

        // asynchronous reset in the middle of a grant to B
        do_reset();
        req  = 4'b0010;
        data = 4'b0010;
        step();
        check("mid_grant", {4'b0, grant}, 8'h02);
        step();
        check("mid_q", {7'b0, q}, 8'h01);
        #2 rst_n = 1'b0;
        #1;
        check("async_grant", {4'b0, grant}, 8'h00);
        check("async_q", {7'b0, q}, 8'h00);
        check("async_sel", {6'b0, select1, select2}, 8'h00);
        check("async_busy", {7'b0, busy}, 8'h00);
        #1 rst_n = 1'b1;
        req = 4'b0110;
        step();
        check("restart_grant", {4'b0, grant}, 8'h02);
        check("restart_sel", {6'b0, select1, select2}, 8'h01);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
